// File: rtl/regfile_pkg.sv
// Shared constants for the two-bank register file: bank codes, reset indices
// and default sizes.
package regfile_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GPR  = 2'b01;
  localparam logic [1:0] RW_FPR  = 2'b10;

  localparam int GP_IDX = 28;
  localparam int SP_IDX = 29;

  function automatic logic rw_valid(input logic [1:0] bank);
    return (bank == RW_GPR) || (bank == RW_FPR);
  endfunction

endpackage

// File: rtl/regfile_sb_regbank.sv
// One register bank: storage, busy scoreboard, writeback bypass on every read
// port, and the "destination blocked" flag used by issue.
module regbank
  import regfile_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter int              NREG      = DEF_NREG,
  parameter int              NRD       = 3,
  parameter int              NWR       = 2,
  parameter logic [1:0]      BANK      = RW_GPR,
  parameter bit              HARD_ZERO = 1'b0,
  parameter bit              HAS_INIT  = 1'b0,
  parameter logic [XLEN-1:0] GP_INIT   = '0,
  parameter logic [XLEN-1:0] SP_INIT   = '0,
  parameter int              AW        = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NRD-1:0][AW-1:0]    rd_addr_i,
  output logic [NRD-1:0][XLEN-1:0]  rd_data_o,
  output logic [NRD-1:0]            rd_busy_o,
  input  logic [NWR-1:0][1:0]       wb_bank_i,
  input  logic [NWR-1:0][AW-1:0]    wb_addr_i,
  input  logic [NWR-1:0][XLEN-1:0]  wb_data_i,
  input  logic [AW-1:0]             iss_addr_i,
  input  logic                      iss_set_i,
  input  logic                      flush_i,
  output logic                      iss_block_o,
  output logic                      any_busy_o
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;

  logic [NWR-1:0]           wb_en;
  logic [NRD-1:0]           rd_hit;
  logic [NRD-1:0][XLEN-1:0] rd_byp;
  logic                     iss_hit;

  function automatic logic [XLEN-1:0] reset_val(input int idx);
    if (HAS_INIT && idx == GP_IDX) return GP_INIT;
    if (HAS_INIT && idx == SP_IDX) return SP_INIT;
    return '0;
  endfunction

  // A hard-wired r0 never sees a write enable, so it never changes or goes busy.
  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      wb_en[p] = (wb_bank_i[p] == BANK) && !(HARD_ZERO && wb_addr_i[p] == '0);
    end
  end

  // Bypass search: later ports overwrite earlier hits, so the highest port wins.
  always_comb begin
    rd_hit  = '0;
    rd_byp  = '0;
    iss_hit = 1'b0;
    for (int r = 0; r < NRD; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (wb_en[p] && wb_addr_i[p] == rd_addr_i[r]) begin
          rd_hit[r] = 1'b1;
          rd_byp[r] = wb_data_i[p];
        end
      end
    end
    for (int p = 0; p < NWR; p++) begin
      if (wb_en[p] && wb_addr_i[p] == iss_addr_i) iss_hit = 1'b1;
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int r = 0; r < NRD; r++) begin
      if (HARD_ZERO && rd_addr_i[r] == '0) begin
        rd_data_o[r] = '0;
        rd_busy_o[r] = 1'b0;
      end else if (rd_hit[r]) begin
        rd_data_o[r] = rd_byp[r];
        rd_busy_o[r] = 1'b0;
      end else begin
        rd_data_o[r] = mem_q[rd_addr_i[r]];
        rd_busy_o[r] = busy_q[rd_addr_i[r]];
      end
    end
  end

  assign iss_block_o = busy_q[iss_addr_i] && !iss_hit
                       && !(HARD_ZERO && iss_addr_i == '0);
  assign any_busy_o  = |busy_q;

  // Writeback clears first, then a new reservation sets: the new producer wins.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int p = 0; p < NWR; p++) begin
      if (wb_en[p]) begin
        mem_d[wb_addr_i[p]]  = wb_data_i[p];
        busy_d[wb_addr_i[p]] = 1'b0;
      end
    end
    if (flush_i) begin
      busy_d = '0;
    end else if (iss_set_i && !(HARD_ZERO && iss_addr_i == '0)) begin
      busy_d[iss_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= reset_val(i);
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= mem_d[i];
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-bank (GPR/FPR) register file with scoreboard; routes read, issue and
// writeback traffic to the bank selected by each port's bank code.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int              XLEN    = DEF_XLEN,
  parameter int              NREG    = DEF_NREG,
  parameter int              NRD     = 3,
  parameter int              NWR     = 2,
  parameter logic [XLEN-1:0] GP_INIT = 32'hf4240,
  parameter logic [XLEN-1:0] SP_INIT = 32'h30,
  parameter int              AW      = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NRD-1:0][1:0]       rd_bank,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0][XLEN-1:0]  rd_data,
  output logic [NRD-1:0]            rd_busy,
  input  logic [1:0]                iss_bank,
  input  logic [AW-1:0]             iss_addr,
  input  logic                      iss_valid,
  output logic                      iss_ready,
  input  logic [NWR-1:0][1:0]       wb_bank,
  input  logic [NWR-1:0][AW-1:0]    wb_addr,
  input  logic [NWR-1:0][XLEN-1:0]  wb_data,
  input  logic                      flush,
  output logic                      any_busy
);

  // Issue handshake: a reservation is taken on a cycle with iss_valid && iss_ready;
  // iss_ready is purely combinational and never depends on iss_valid.

  logic [NRD-1:0][XLEN-1:0] g_rd_data, f_rd_data;
  logic [NRD-1:0]           g_rd_busy, f_rd_busy;
  logic                     g_block, f_block;
  logic                     g_any, f_any;
  logic                     iss_fire;

  assign iss_ready = !flush && !((iss_bank == RW_GPR && g_block) ||
                                 (iss_bank == RW_FPR && f_block));
  assign iss_fire  = iss_valid && iss_ready;
  assign any_busy  = g_any | f_any;

  regbank #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BANK(RW_GPR),
    .HARD_ZERO(1'b1), .HAS_INIT(1'b1), .GP_INIT(GP_INIT), .SP_INIT(SP_INIT), .AW(AW)
  ) u_gpr (
    .clk        (clk),
    .rstn       (rstn),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (g_rd_data),
    .rd_busy_o  (g_rd_busy),
    .wb_bank_i  (wb_bank),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .iss_addr_i (iss_addr),
    .iss_set_i  (iss_fire && iss_bank == RW_GPR),
    .flush_i    (flush),
    .iss_block_o(g_block),
    .any_busy_o (g_any)
  );

  regbank #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BANK(RW_FPR),
    .HARD_ZERO(1'b0), .HAS_INIT(1'b0), .GP_INIT('0), .SP_INIT('0), .AW(AW)
  ) u_fpr (
    .clk        (clk),
    .rstn       (rstn),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (f_rd_data),
    .rd_busy_o  (f_rd_busy),
    .wb_bank_i  (wb_bank),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .iss_addr_i (iss_addr),
    .iss_set_i  (iss_fire && iss_bank == RW_FPR),
    .flush_i    (flush),
    .iss_block_o(f_block),
    .any_busy_o (f_any)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int r = 0; r < NRD; r++) begin
      if (rd_bank[r] == RW_GPR) begin
        rd_data[r] = g_rd_data[r];
        rd_busy[r] = g_rd_busy[r];
      end else if (rd_bank[r] == RW_FPR) begin
        rd_data[r] = f_rd_data[r];
        rd_busy[r] = f_rd_busy[r];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb, plus a hand-written async
// reset sequence.
module tb_regfile_sb;

  localparam logic [1:0] N = 2'b00, G = 2'b01, F = 2'b10, U = 2'b11;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [2:0][1:0]      rd_bank;
  logic [2:0][4:0]      rd_addr;
  logic [2:0][31:0]     rd_data;
  logic [2:0]           rd_busy;
  logic [1:0]           iss_bank;
  logic [4:0]           iss_addr;
  logic                 iss_valid;
  logic                 iss_ready;
  logic [1:0][1:0]      wb_bank;
  logic [1:0][4:0]      wb_addr;
  logic [1:0][31:0]     wb_data;
  logic                 flush;
  logic                 any_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk      (clk),
    .rstn     (rstn),
    .rd_bank  (rd_bank),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .iss_bank (iss_bank),
    .iss_addr (iss_addr),
    .iss_valid(iss_valid),
    .iss_ready(iss_ready),
    .wb_bank  (wb_bank),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .flush    (flush),
    .any_busy (any_busy)
  );

  typedef struct {
    string            name;
    logic [2:0][1:0]  rb;
    logic [2:0][4:0]  ra;
    logic [1:0]       ib;
    logic [4:0]       ia;
    logic             iv;
    logic [1:0][1:0]  wb;
    logic [1:0][4:0]  wa;
    logic [1:0][31:0] wd;
    logic             fl;
    logic [2:0][31:0] ed;
    logic [2:0]       ebz;
    logic             erdy;
    logic             eab;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string n,
    input logic [1:0] b0, input logic [4:0] a0,
    input logic [1:0] b1, input logic [4:0] a1,
    input logic [1:0] b2, input logic [4:0] a2,
    input logic [1:0] ib, input logic [4:0] ia, input logic iv,
    input logic [1:0] w0b, input logic [4:0] w0a, input logic [31:0] w0d,
    input logic [1:0] w1b, input logic [4:0] w1a, input logic [31:0] w1d,
    input logic fl,
    input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
    input logic [2:0] bz, input logic rdy, input logic ab);
    vec_t v;
    v.name = n;
    v.rb[0] = b0; v.ra[0] = a0;
    v.rb[1] = b1; v.ra[1] = a1;
    v.rb[2] = b2; v.ra[2] = a2;
    v.ib = ib; v.ia = ia; v.iv = iv;
    v.wb[0] = w0b; v.wa[0] = w0a; v.wd[0] = w0d;
    v.wb[1] = w1b; v.wa[1] = w1a; v.wd[1] = w1d;
    v.fl = fl;
    v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2;
    v.ebz = bz; v.erdy = rdy; v.eab = ab;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic idle();
    rd_bank = '0; rd_addr = '0;
    iss_bank = N; iss_addr = '0; iss_valid = 1'b0;
    wb_bank = '0; wb_addr = '0; wb_data = '0;
    flush = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    rd_bank = v.rb; rd_addr = v.ra;
    iss_bank = v.ib; iss_addr = v.ia; iss_valid = v.iv;
    wb_bank = v.wb; wb_addr = v.wa; wb_data = v.wd;
    flush = v.fl;
  endtask

  initial begin
    //          name            rd0     rd1     rd2     issue      wb0               wb1              fl  exp data                              busy    rdy ab
    vecs.push_back(mk("reset_gpr",   G,28, G,29, G,5,  N,0,0,   N,0,0,            N,0,0,           0, 32'hf4240,32'h30,0,                3'b000, 1, 0));
    vecs.push_back(mk("reset_fpr0",  F,0,  G,0,  N,3,  G,7,1,   N,0,0,            N,0,0,           0, 0,0,0,                             3'b000, 1, 0));
    vecs.push_back(mk("g7_busy",     G,7,  G,28, F,0,  N,0,0,   N,0,0,            N,0,0,           0, 0,32'hf4240,0,                     3'b001, 1, 1));
    vecs.push_back(mk("g7_bypass",   G,7,  G,7,  F,3,  N,0,0,   G,7,32'hDEAD,     N,0,0,           0, 32'hDEAD,32'hDEAD,0,               3'b000, 1, 1));
    vecs.push_back(mk("f3_dual_wb",  G,7,  F,3,  F,3,  N,0,0,   F,3,32'h1,        F,3,32'h2,       0, 32'hDEAD,32'h2,32'h2,              3'b000, 1, 0));
    vecs.push_back(mk("f3_stored",   F,3,  G,7,  G,29, G,7,1,   N,0,0,            N,0,0,           0, 32'h2,32'hDEAD,32'h30,             3'b000, 1, 0));
    vecs.push_back(mk("g7_blocked",  G,7,  G,0,  F,3,  G,7,1,   N,0,0,            N,0,0,           0, 32'hDEAD,0,32'h2,                  3'b001, 0, 1));
    vecs.push_back(mk("g7_set_wins", G,7,  F,3,  G,28, G,7,1,   N,0,0,            G,7,32'hBEEF,    0, 32'hBEEF,32'h2,32'hf4240,          3'b000, 1, 1));
    vecs.push_back(mk("gpr0_write",  G,0,  G,7,  F,3,  G,0,1,   G,0,32'h55,       N,0,0,           0, 0,32'hBEEF,32'h2,                  3'b010, 1, 1));
    vecs.push_back(mk("g7_clear",    G,0,  G,7,  G,0,  N,0,0,   G,7,32'h1234,     N,0,0,           0, 0,32'h1234,0,                      3'b000, 1, 1));
    vecs.push_back(mk("iss_g4",      G,0,  G,7,  F,9,  G,4,1,   N,0,0,            N,0,0,           0, 0,32'h1234,0,                      3'b000, 1, 0));
    vecs.push_back(mk("iss_f9",      G,4,  F,9,  G,10, F,9,1,   N,0,0,            N,0,0,           0, 0,0,0,                             3'b001, 1, 1));
    vecs.push_back(mk("flush",       G,4,  F,9,  G,10, G,10,1,  G,10,32'h77,      N,0,0,           1, 0,0,32'h77,                        3'b011, 0, 1));
    vecs.push_back(mk("post_flush",  G,4,  F,9,  G,10, N,0,0,   N,0,0,            N,0,0,           0, 0,0,32'h77,                        3'b000, 1, 0));
    vecs.push_back(mk("bank11_wb",   U,10, G,10, F,10, N,0,0,   U,10,32'hFFFF,    F,0,32'hABC,     0, 0,32'h77,0,                        3'b000, 1, 0));
    vecs.push_back(mk("fpr0_store",  F,0,  G,10, N,0,  N,0,0,   N,0,0,            N,0,0,           0, 32'hABC,32'h77,0,                  3'b000, 1, 0));
    vecs.push_back(mk("iss_f9_b",    F,9,  N,0,  N,0,  F,9,1,   N,0,0,            N,0,0,           0, 0,0,0,                             3'b000, 1, 0));
    vecs.push_back(mk("f9_blocked",  F,9,  N,0,  N,0,  F,9,1,   N,0,0,            N,0,0,           0, 0,0,0,                             3'b001, 0, 1));
    vecs.push_back(mk("f9_wb",       F,9,  G,10, N,0,  N,0,0,   F,9,32'h5,        N,0,0,           0, 32'h5,32'h77,0,                    3'b000, 1, 1));
    vecs.push_back(mk("iss_bank11",  F,9,  G,10, N,0,  U,0,1,   N,0,0,            N,0,0,           0, 32'h5,32'h77,0,                    3'b000, 1, 0));

    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);

    foreach (vecs[k]) begin
      #1;
      apply(vecs[k]);
      @(negedge clk);
      for (int r = 0; r < 3; r++) begin
        chk($sformatf("%s.rd_data%0d", vecs[k].name, r), rd_data[r], vecs[k].ed[r]);
      end
      chk({vecs[k].name, ".rd_busy"},   {29'd0, rd_busy},   {29'd0, vecs[k].ebz});
      chk({vecs[k].name, ".iss_ready"}, {31'd0, iss_ready}, {31'd0, vecs[k].erdy});
      chk({vecs[k].name, ".any_busy"},  {31'd0, any_busy},  {31'd0, vecs[k].eab});
      @(posedge clk);
    end

    // Asynchronous reset in the middle of traffic.
    #1;
    idle();
    iss_bank = G; iss_addr = 5'd4; iss_valid = 1'b1;
    wb_bank[0] = G; wb_addr[0] = 5'd5; wb_data[0] = 32'h99;
    @(posedge clk);
    #1;
    idle();
    rd_bank[0] = G; rd_addr[0] = 5'd5;
    rd_bank[1] = G; rd_addr[1] = 5'd28;
    rd_bank[2] = F; rd_addr[2] = 5'd3;
    #1;
    chk("pre_rst.any_busy", {31'd0, any_busy}, 32'd1);
    chk("pre_rst.g5",       rd_data[0],        32'h99);
    rstn = 1'b0;
    #1;
    chk("async_rst.any_busy", {31'd0, any_busy}, 32'd0);
    chk("async_rst.g5",       rd_data[0],        32'h0);
    chk("async_rst.g28",      rd_data[1],        32'hf4240);
    chk("async_rst.f3",       rd_data[2],        32'h0);
    wb_bank[0] = G; wb_addr[0] = 5'd6; wb_data[0] = 32'h11;
    iss_bank = G; iss_addr = 5'd6; iss_valid = 1'b1;
    @(posedge clk);
    #1;
    idle();
    rd_bank[0] = G; rd_addr[0] = 5'd6;
    rd_bank[1] = G; rd_addr[1] = 5'd29;
    #1;
    chk("in_rst.g6",       rd_data[0],         32'h0);
    chk("in_rst.g29",      rd_data[1],         32'h30);
    chk("in_rst.any_busy", {31'd0, any_busy},  32'd0);
    @(negedge clk);
    rstn = 1'b1;
    iss_bank = G; iss_addr = 5'd6; iss_valid = 1'b0;
    #1;
    chk("post_rst.iss_ready", {31'd0, iss_ready}, 32'd1);
    chk("post_rst.g6_busy",   {31'd0, rd_busy[0]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
